// File: rtl/pwm_pkg.sv
// Shared types and constants for the multi-channel PWM generator.
package pwm_pkg;

    localparam int unsigned PRESCALE_1MS = 32768;
    localparam int unsigned PERIOD_10MS  = 10;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Counter width for a modulus of n; never narrower than one bit.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pwm_timebase.sv
// Prescaler plus tick counter; one wrap of the tick counter is one PWM period.
module pwm_timebase
    import pwm_pkg::*;
#(
    parameter int unsigned PRESCALE = PRESCALE_1MS,
    parameter int unsigned PERIOD   = PERIOD_10MS
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clr,
    input  logic                      en,
    output logic [cnt_w(PERIOD)-1:0]  tick_cnt,
    output logic                      period_end
);

    localparam int unsigned PS_W = cnt_w(PRESCALE);
    localparam int unsigned TK_W = cnt_w(PERIOD);
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);
    localparam logic [TK_W-1:0] TK_LAST = TK_W'(PERIOD - 1);

    logic [PS_W-1:0] presc;
    logic            tick;

    assign tick       = en && (presc == PS_LAST);
    assign period_end = tick && (tick_cnt == TK_LAST);

    // Synchronous clear has priority over counting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc    <= '0;
            tick_cnt <= '0;
        end else if (clr) begin
            presc    <= '0;
            tick_cnt <= '0;
        end else if (en) begin
            if (tick) begin
                presc    <= '0;
                tick_cnt <= period_end ? '0 : tick_cnt + TK_W'(1);
            end else begin
                presc <= presc + PS_W'(1);
            end
        end
    end

endmodule

// File: rtl/pwm_multi.sv
// Multi-channel PWM: shared timebase, per-channel shadow/active duties,
// continuous or counted-burst operation.
module pwm_multi
    import pwm_pkg::*;
#(
    parameter int unsigned NCH      = 4,
    parameter int unsigned PRESCALE = PRESCALE_1MS,
    parameter int unsigned PERIOD   = PERIOD_10MS,
    parameter int unsigned DUTY_W   = 4,
    parameter int unsigned BURST_W  = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   stop,
    input  logic                   mode,
    input  logic [BURST_W-1:0]     burst_len,
    input  logic                   duty_wr,
    input  logic [cnt_w(NCH)-1:0]  duty_ch,
    input  logic [DUTY_W-1:0]      duty_val,
    output logic [NCH-1:0]         pwm_out,
    output logic                   busy,
    output logic                   period_end,
    output logic                   done
);

    localparam int unsigned CH_W  = cnt_w(NCH);
    localparam int unsigned TK_W  = cnt_w(PERIOD);
    localparam int unsigned CMP_W = (DUTY_W > TK_W) ? DUTY_W : TK_W;

    state_t              state;
    state_t              state_next;
    logic                run;
    logic                accept;
    logic                tb_clear;
    logic [TK_W-1:0]     tick_cnt;
    logic                mode_lat;
    logic [BURST_W-1:0]  burst_lat;
    logic [BURST_W-1:0]  burst_cnt;
    logic [DUTY_W-1:0]   shadow [NCH];
    logic [DUTY_W-1:0]   active [NCH];

    assign run      = (state == RUN);
    assign accept   = !run && start && !stop;
    assign tb_clear = !run || stop;
    assign busy     = run;
    assign done     = run && period_end && mode_lat && !stop
                      && (burst_cnt == burst_lat - BURST_W'(1));

    pwm_timebase #(
        .PRESCALE (PRESCALE),
        .PERIOD   (PERIOD)
    ) u_timebase (
        .clk        (clk),
        .rst        (rst),
        .clr        (tb_clear),
        .en         (run),
        .tick_cnt   (tick_cnt),
        .period_end (period_end)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = RUN;
            RUN:     if (stop || done) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Burst configuration is frozen at start; the period count restarts with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_lat  <= 1'b0;
            burst_lat <= '0;
            burst_cnt <= '0;
        end else if (accept) begin
            mode_lat  <= mode;
            burst_lat <= (burst_len == '0) ? BURST_W'(1) : burst_len;
            burst_cnt <= '0;
        end else if (stop) begin
            burst_cnt <= '0;
        end else if (run && period_end) begin
            burst_cnt <= burst_cnt + BURST_W'(1);
        end
    end

    // Active duties only change at period boundaries so no pulse is ever cut.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++) begin
                shadow[i] <= '0;
                active[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (accept || period_end) begin
                    active[i] <= shadow[i];
                end
                if (duty_wr && (duty_ch == CH_W'(i))) begin
                    shadow[i] <= duty_val;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm_out <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                pwm_out[i] <= run && !stop && (CMP_W'(tick_cnt) < CMP_W'(active[i]));
            end
        end
    end

endmodule

// File: tb/tb_pwm_multi.sv
// Bench for pwm_multi: a 4-channel and a 3-channel instance share stimulus and
// are checked every cycle against a clock-count model plus directed window counts.
module tb_pwm_multi;

    localparam int PRESCALE = 4;
    localparam int PERIOD   = 10;
    localparam int P        = PRESCALE * PERIOD;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       mode = 1'b0;
    logic [7:0] burst_len = 8'd0;
    logic       duty_wr = 1'b0;
    logic [1:0] duty_ch = 2'd0;
    logic [3:0] duty_val = 4'd0;

    logic [3:0] pwm4;
    logic       busy4, pe4, done4;
    logic [2:0] pwm3;
    logic       busy3, pe3, done3;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pwm_multi #(.NCH(4), .PRESCALE(PRESCALE), .PERIOD(PERIOD), .DUTY_W(4), .BURST_W(8)) u_dut4 (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .mode(mode),
        .burst_len(burst_len), .duty_wr(duty_wr), .duty_ch(duty_ch), .duty_val(duty_val),
        .pwm_out(pwm4), .busy(busy4), .period_end(pe4), .done(done4)
    );

    pwm_multi #(.NCH(3), .PRESCALE(PRESCALE), .PERIOD(PERIOD), .DUTY_W(4), .BURST_W(8)) u_dut3 (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .mode(mode),
        .burst_len(burst_len), .duty_wr(duty_wr), .duty_ch(duty_ch), .duty_val(duty_val),
        .pwm_out(pwm3), .busy(busy3), .period_end(pe3), .done(done3)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: k counts clocks since the start edge; position in period is k mod P.
    bit running;
    int k, pdone, bl_m;
    bit mode_m;
    int shadow [2][4];
    int active [2][4];
    bit exp_pwm [2][4];
    int nch [2] = '{4, 3};
    bit chk_en = 1'b0;

    task automatic model_reset();
        running = 1'b0; k = 0; pdone = 0; bl_m = 0; mode_m = 1'b0;
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 4; i++) begin
                shadow[d][i] = 0; active[d][i] = 0; exp_pwm[d][i] = 1'b0;
            end
    endtask

    task automatic model_step();
        int pos;
        bit pe, dn, acc;
        pos = k % P;
        pe  = running && (pos == P - 1);
        dn  = pe && mode_m && (pdone == bl_m - 1) && !stop;
        acc = !running && start && !stop;
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 4; i++)
                exp_pwm[d][i] = running && !stop && (pos / PRESCALE < active[d][i]);
        if (acc || pe)
            for (int d = 0; d < 2; d++)
                for (int i = 0; i < 4; i++) active[d][i] = shadow[d][i];
        if (duty_wr)
            for (int d = 0; d < 2; d++)
                if (int'(duty_ch) < nch[d]) shadow[d][int'(duty_ch)] = int'(duty_val);
        if (stop) begin
            running = 1'b0;
        end else if (acc) begin
            running = 1'b1; k = 0; pdone = 0; mode_m = mode;
            bl_m = (burst_len == 8'd0) ? 1 : int'(burst_len);
        end else if (running) begin
            if (pe) pdone++;
            if (dn) running = 1'b0;
            k++;
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) model_reset();
            else model_step();
        end
    end

    // Per-cycle comparison of both instances against the model.
    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            logic [3:0] e4;
            logic [2:0] e3;
            bit pe_now, dn_now;
            for (int i = 0; i < 4; i++) e4[i] = exp_pwm[0][i];
            for (int i = 0; i < 3; i++) e3[i] = exp_pwm[1][i];
            pe_now = running && (k % P == P - 1);
            dn_now = pe_now && mode_m && (pdone == bl_m - 1) && !stop;
            check("pwm4", 32'(pwm4), 32'(e4));
            check("pwm3", 32'(pwm3), 32'(e3));
            check("busy4", 32'(busy4), 32'(running));
            check("busy3", 32'(busy3), 32'(running));
            check("period_end4", 32'(pe4), 32'(pe_now));
            check("period_end3", 32'(pe3), 32'(pe_now));
            check("done4", 32'(done4), 32'(dn_now));
            check("done3", 32'(done3), 32'(dn_now));
        end
    end

    int hi [4];
    int hi3 [3];
    int rise1, pe_n, done_n, busy_n, done_at, done_pe;

    task automatic count_window(input int n);
        logic prev1;
        for (int i = 0; i < 4; i++) hi[i] = 0;
        for (int i = 0; i < 3; i++) hi3[i] = 0;
        rise1 = 0; pe_n = 0; done_n = 0; busy_n = 0; done_at = -1; done_pe = 0;
        prev1 = 1'b0;
        for (int s = 0; s < n; s++) begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) hi[i] += int'(pwm4[i]);
            for (int i = 0; i < 3; i++) hi3[i] += int'(pwm3[i]);
            if (pwm4[1] && !prev1) rise1++;
            prev1 = pwm4[1];
            pe_n   += int'(pe4);
            busy_n += int'(busy4);
            if (done4) begin
                done_n++;
                if (done_at < 0) done_at = s;
                if (pe4) done_pe++;
            end
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [1:0] ch, input logic [3:0] v);
        duty_wr = 1'b1; duty_ch = ch; duty_val = v;
        step();
        duty_wr = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1; step(); start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1; step(); stop = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        #2;
        chk_en = 1'b1;
        check("reset_pwm", 32'(pwm4), 32'd0);
        check("reset_busy", 32'(busy4), 32'd0);
        check("reset_pe", 32'(pe4), 32'd0);
        check("reset_done", 32'(done4), 32'd0);
        step(3);
        rst = 1'b0;
        step(2);

        // Continuous: duties {0,3,10,15}
        wr(2'd0, 4'd0); wr(2'd1, 4'd3); wr(2'd2, 4'd10); wr(2'd3, 4'd15);
        mode = 1'b0;
        pulse_start();
        count_window(80);
        check("cont_ch0_high", 32'(hi[0]), 32'd0);
        check("cont_ch1_high", 32'(hi[1]), 32'd24);
        check("cont_ch1_pulses", 32'(rise1), 32'd2);
        check("cont_ch2_high", 32'(hi[2]), 32'd79);
        check("cont_ch3_high", 32'(hi[3]), 32'd79);
        check("cont_period_end", 32'(pe_n), 32'd2);

        // Shadow write mid-period, then one coinciding with period_end
        step(11);
        wr(2'd1, 4'd5);
        count_window(70);
        check("shadow_mid_ch1", 32'(hi[1]), 32'd22);
        step(39);
        wr(2'd1, 4'd2);
        count_window(81);
        check("shadow_pe_ch1", 32'(hi[1]), 32'd28);
        pulse_stop();
        check("stopped_busy", 32'(busy4), 32'd0);
        check("stopped_pwm", 32'(pwm4), 32'd0);

        // Stop after 17 clocks of running
        pulse_start();
        step(16);
        pulse_stop();
        check("stop17_pwm", 32'(pwm4), 32'd0);
        check("stop17_busy", 32'(busy4), 32'd0);
        count_window(20);
        check("stop17_no_done", 32'(done_n), 32'd0);
        check("stop17_ch2_low", 32'(hi[2]), 32'd0);

        // start and stop together stays idle
        start = 1'b1; stop = 1'b1; step(); start = 1'b0; stop = 1'b0;
        check("conflict_busy", 32'(busy4), 32'd0);
        count_window(10);
        check("conflict_busy_window", 32'(busy_n), 32'd0);

        // start during RUN does not disturb the timebase
        pulse_start();
        step(20);
        pulse_start();
        count_window(59);
        check("restart_pe", 32'(pe_n), 32'd2);
        check("restart_ch1", 32'(hi[1]), 32'd8);
        pulse_stop();

        // Burst of 3 periods with ch1 duty 3
        wr(2'd1, 4'd3);
        mode = 1'b1; burst_len = 8'd3;
        pulse_start();
        count_window(130);
        check("burst_pulses", 32'(rise1), 32'd3);
        check("burst_ch1_high", 32'(hi[1]), 32'd36);
        check("burst_ch2_high", 32'(hi[2]), 32'd120);
        check("burst_done_n", 32'(done_n), 32'd1);
        check("burst_done_at", 32'(done_at), 32'd119);
        check("burst_done_pe", 32'(done_pe), 32'd1);
        check("burst_pe_n", 32'(pe_n), 32'd3);
        check("burst_busy_n", 32'(busy_n), 32'd120);
        step();
        burst_len = 8'd0;
        pulse_start();
        count_window(60);
        check("burst0_done_n", 32'(done_n), 32'd1);
        check("burst0_done_at", 32'(done_at), 32'd39);
        check("burst0_pe_n", 32'(pe_n), 32'd1);
        check("burst0_busy_n", 32'(busy_n), 32'd40);
        mode = 1'b0;
        step();

        // Asynchronous reset mid-pulse
        pulse_start();
        step(5);
        #2;
        rst = 1'b1;
        #1;
        check("async_pwm4", 32'(pwm4), 32'd0);
        check("async_pwm3", 32'(pwm3), 32'd0);
        check("async_busy", 32'(busy4), 32'd0);
        step(3);
        rst = 1'b0;
        step();
        pulse_start();
        count_window(80);
        check("post_reset_ch1", 32'(hi[1]), 32'd0);
        check("post_reset_ch2", 32'(hi[2]), 32'd0);
        check("post_reset_ch3", 32'(hi[3]), 32'd0);
        check("post_reset_pe", 32'(pe_n), 32'd2);
        check("post_reset_busy", 32'(busy_n), 32'd80);
        pulse_stop();

        // Channel index 3 is out of range for the 3-channel instance
        wr(2'd2, 4'd4);
        wr(2'd3, 4'd7);
        pulse_start();
        count_window(40);
        check("badidx_ch0", 32'(hi3[0]), 32'd0);
        check("badidx_ch1", 32'(hi3[1]), 32'd0);
        check("badidx_ch2", 32'(hi3[2]), 32'd16);
        check("goodidx_ch3_4ch", 32'(hi[3]), 32'd28);
        pulse_stop();
        step(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pwm_multi.md
# pwm_multi

Parametrised multi-channel PWM generator. It is the successor to the single-channel fixed 30 % PWM. A shared prescaler and tick counter define one PWM period, and each of `NCH` channels compares the tick count against its own programmable duty. It supports continuous or counted-burst operation, with glitch-free duty updates at period boundaries. It sits under the board-control logic, driven from the 32.768 MHz system clock.

## Interface
- `NCH`, 4, number of PWM channels
- `PRESCALE`, 32768, clocks per tick (1 ms at 32.768 MHz), ≥2
- `PERIOD`, 10, ticks per PWM period, ≥2
- `DUTY_W`, 4, duty field width; must hold `PERIOD`
- `BURST_W`, 8, burst-length field width
- `clk` in 1: system clock; single clock domain
- `rst` in 1: asynchronous, active-high reset
- `start` in 1: one-cycle pulse, begin operation
- `stop` in 1: one-cycle pulse, abort operation
- `mode` in 1: 0 = continuous, 1 = burst; sampled on accepted `start`
- `burst_len` in BURST_W: periods per burst; sampled on accepted `start`; 0 treated as 1
- `duty_wr` in 1: write strobe for a shadow duty register
- `duty_ch` in $clog2(NCH): channel index for the write
- `duty_val` in DUTY_W: high ticks per period
- `pwm_out` out NCH: registered PWM outputs
- `busy` out 1: high while in RUN
- `period_end` out 1: one-cycle pulse on the last clock of each period
- `done` out 1: one-cycle pulse when a burst completes

## Operation
- **FSM states:** IDLE, RUN.
- **IDLE → RUN** on `start`.
  - Clears prescaler and tick counter.
  - Copies all shadow duties to the active duties.
  - Latches `mode` and `burst_len`; clears the period counter.
- **`start` while RUN:** ignored.
- **`stop` in any state:** forces IDLE.
  - Counters are cleared.
  - `pwm_out` is 0 from the next edge.
  - `done` does not pulse.
- **`start` and `stop` in the same cycle:** `stop` wins.
- **Prescaler:** counts 0..PRESCALE-1. `tick` = prescaler terminal.
- **Tick counter:** advances on `tick`, counts 0..PERIOD-1.
- **Period end:** `period_end` = tick counter terminal AND `tick`.
- **Per channel:** `pwm_out[i]` is registered as (RUN AND tick_cnt < duty_act[i]).
  - duty 0 gives constant low.
  - duty ≥ PERIOD gives constant high.
- **Duty writes:** `duty_wr` writes `shadow[duty_ch]` in any state.
  - Writes with `duty_ch` ≥ NCH are ignored.
  - Active duties reload from the shadows only on accepted `start` and on `period_end`.
  - A write coinciding with `period_end` lands in the shadow and reaches the active duties one period later. The active duties load the pre-write shadow value.
- **Burst mode:** the period counter increments on `period_end`.
  - On the `period_end` where count = burst_len-1: `done` pulses and the FSM goes to IDLE.
- **Continuous mode:** runs until `stop`.

## Timing
- **Reset values:** `pwm_out`=0, `busy`=0, `period_end`=0, `done`=0. State IDLE, all counters 0, shadow and active duties 0, latched mode 0.
- **Start:** `start` sampled at edge E0 gives `busy`=1 and counters=0 after E0. `pwm_out` reflects tick 0 after E1.
  - Output latency is one clock behind the counter state.
- **Pulse width:** each output high run is exactly duty×PRESCALE clocks. The period is exactly PERIOD×PRESCALE clocks.
- **Burst end:**
  - `done` and the final `period_end` are asserted in the same cycle.
  - `busy` falls at the following edge.
  - The last `pwm_out` low/high sample belongs to the final tick.
- **Reset mid-operation:** all state and outputs return to reset values immediately (asynchronous). No pulse is emitted.

## Structure
- **Package `pwm_pkg`:**
  - state enum (IDLE, RUN)
  - default parameter constants (PRESCALE_1MS = 32768, PERIOD_10MS = 10)
  - a function returning counter widths via $clog2
- **Sub-module `pwm_timebase`:** prescaler, tick counter, `tick` and `period_end` generation, with synchronous clear input.
- **Top:** FSM, burst counter, shadow/active duty arrays, per-channel comparators.

## Test plan
All scenarios use PRESCALE=4, PERIOD=10, NCH=4.
- **Continuous run:** duties {0,3,10,15}, mode 0, `start` → ch0 never high; ch1 high 12 clocks of every 40; ch2 and ch3 constantly high; `period_end` every 40 clocks.
- **Burst:** mode 1, burst_len=3, duty 3 → exactly 3 high pulses on ch1; `done` on the 120th clock after `start`, coincident with the third `period_end`; `busy` low one edge later. burst_len=0 → exactly 1 period.
- **Shadow update:** write ch1 duty 5 mid-period → current period still 12 clocks high, next period 20. A write on the `period_end` cycle → takes effect one period later.
- **Stop and command conflicts:** `stop` at clock 17 → all `pwm_out` 0 from clock 18, no `done`. `start`+`stop` in the same cycle → stays IDLE. `start` during RUN → no counter disturbance.
- **Async reset:** `rst` asserted mid-high pulse → all outputs 0 without waiting for a clock edge. After release, `start` → identical waveform to the first run, with shadows 0 (all outputs low).
- **Bad index:** `duty_wr` with `duty_ch`=5 (out of range for NCH=4... index width wraps, use NCH=3, `duty_ch`=3) → no shadow changes.
